// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command sequencer: FSM states and
// the layout of a buffered command entry {rw, addr, wdata}.
package apb_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int   CMD_W     = 17;
   localparam logic RW_WRITE  = 1'b1;
   localparam logic RW_READ   = 1'b0;

   localparam int   WDATA_LSB = 0;
   localparam int   ADDR_LSB  = 8;
   localparam int   RW_BIT    = 16;

   function automatic logic [CMD_W-1:0] pack_cmd(input logic       rw,
                                                 input logic [7:0] addr,
                                                 input logic [7:0] wdata);
      return {rw, addr, wdata};
   endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous show-ahead FIFO; dout is the head entry whenever empty is low.
// Push is ignored when full and pop when empty; push+pop keeps the count.
module apb_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Buffers host read/write commands and replays each onto the APB top as a fixed
// XFER_CYCLES transfer window plus one idle cycle; read data lands in a held response.
module apb_cmd_sequencer
   import apb_cmd_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int XFER_CYCLES = 2
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_rw,
   input  logic [7:0]             cmd_addr,
   input  logic [7:0]             cmd_wdata,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [7:0]             rsp_rdata,
   output logic [7:0]             rsp_addr,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   transfer,
   output logic                   READ_WRITE,
   output logic [7:0]             apb_write_paddr,
   output logic [7:0]             apb_write_data,
   output logic [7:0]             apb_read_paddr,
   input  logic [7:0]             apb_read_data_out
);

   localparam int CNT_W = $clog2(XFER_CYCLES + 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cur_rw_q, cur_rw_d;
   logic [7:0]         cur_addr_q, cur_addr_d;
   logic [7:0]         cur_wdata_q, cur_wdata_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [7:0]         rsp_rdata_q, rsp_rdata_d;
   logic [7:0]         rsp_addr_q, rsp_addr_d;

   logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CMD_W-1:0]   fifo_head;
   logic               head_ok;

   assign cmd_ready = !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;

   apb_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (PCLK),
      .rst   (PRESET),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (pack_cmd(cmd_rw, cmd_addr, cmd_wdata)),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A read may only start once the response register is free (or freeing now),
   // so the GAP-cycle capture can never overwrite an unconsumed response.
   assign head_ok = !fifo_empty &&
                    (fifo_head[RW_BIT] == RW_WRITE || !rsp_valid_q || rsp_ready);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_rw_d    = cur_rw_q;
      cur_addr_d  = cur_addr_q;
      cur_wdata_d = cur_wdata_q;
      fifo_pop    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (head_ok) begin
               fifo_pop    = 1'b1;
               cur_rw_d    = fifo_head[RW_BIT];
               cur_addr_d  = fifo_head[ADDR_LSB +: 8];
               cur_wdata_d = fifo_head[WDATA_LSB +: 8];
               cnt_d       = '0;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (cnt_q == CNT_W'(XFER_CYCLES - 1)) begin
               state_d = GAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_addr_d  = rsp_addr_q;
      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
      if (state_q == GAP && cur_rw_q == RW_READ) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = apb_read_data_out;
         rsp_addr_d  = cur_addr_q;
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cur_rw_q    <= 1'b0;
         cur_addr_q  <= '0;
         cur_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_rw_q    <= cur_rw_d;
         cur_addr_q  <= cur_addr_d;
         cur_wdata_q <= cur_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_addr_q  <= rsp_addr_d;
      end
   end

   // transfer decodes the state flop directly so async reset drops it at once.
   assign transfer        = (state_q == ISSUE);
   assign READ_WRITE      = cur_rw_q;
   assign apb_write_paddr = cur_addr_q;
   assign apb_read_paddr  = cur_addr_q;
   assign apb_write_data  = cur_wdata_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_addr  = rsp_addr_q;
   assign busy      = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed and random stimulus for apb_cmd_sequencer; a negedge monitor compares every
// issued transfer and read response with an in-order command queue and memory model.
module tb_apb_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int XFER  = 2;

   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       cmd_valid, cmd_ready, cmd_rw;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_rdata, rsp_addr;
   logic       busy;
   logic [2:0] fifo_count;
   logic       transfer, READ_WRITE;
   logic [7:0] apb_write_paddr, apb_write_data, apb_read_paddr, apb_read_data_out;

   apb_cmd_sequencer #(.DEPTH(DEPTH), .XFER_CYCLES(XFER)) dut (
      .PCLK              (PCLK),
      .PRESET            (PRESET),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_rw            (cmd_rw),
      .cmd_addr          (cmd_addr),
      .cmd_wdata         (cmd_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_rdata         (rsp_rdata),
      .rsp_addr          (rsp_addr),
      .busy              (busy),
      .fifo_count        (fifo_count),
      .transfer          (transfer),
      .READ_WRITE        (READ_WRITE),
      .apb_write_paddr   (apb_write_paddr),
      .apb_write_data    (apb_write_data),
      .apb_read_paddr    (apb_read_paddr),
      .apb_read_data_out (apb_read_data_out)
   );

   always #5 PCLK = ~PCLK;

   // Stand-in for the APB top: a zero-wait memory.
   logic [7:0] slave_mem [256];
   assign apb_read_data_out = slave_mem[apb_read_paddr];
   always @(posedge PCLK) begin
      if (transfer && READ_WRITE) slave_mem[apb_write_paddr] = apb_write_data;
   end

   typedef struct {
      logic       rw;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
   } cmd_t;

   cmd_t       exp_q[$];
   logic [7:0] model_mem [256];
   int         n_chk = 0;
   int         n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_t(input string tag, input bit cond);
      n_chk++;
      assert (cond) else begin
         n_err++;
         $error("FAIL %s: observed=0 expected=1", tag);
      end
   endtask

   // Monitor: occupancy = accepted - issued; each rising transfer consumes the queue head.
   bit   mon_en = 1'b0;
   bit   prev_tr, in_gap, chk_rsp, pend;
   cmd_t cur, pend_c;
   int   occ, hi_run, lo_run;

   always @(negedge PCLK) begin
      if (!mon_en) begin
         exp_q.delete();
         occ = 0; prev_tr = 1'b0; pend = 1'b0; chk_rsp = 1'b0;
         hi_run = 0; lo_run = 100;
      end else begin
         if (pend) begin
            occ++;
            if (pend_c.rw) model_mem[pend_c.addr] = pend_c.wdata;
            else           pend_c.rdata = model_mem[pend_c.addr];
            exp_q.push_back(pend_c);
            pend = 1'b0;
         end
         if (chk_rsp) begin
            chk("mon_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("mon_rsp_rdata", 32'(rsp_rdata), 32'(cur.rdata));
            chk("mon_rsp_addr",  32'(rsp_addr),  32'(cur.addr));
            chk_rsp = 1'b0;
         end
         in_gap = 1'b0;
         if (transfer && !prev_tr) begin
            chk_t("mon_issue_spacing", lo_run >= 2);
            chk_t("mon_issue_expected", exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               occ--;
               chk("mon_rw",    32'(READ_WRITE),      32'(cur.rw));
               chk("mon_waddr", 32'(apb_write_paddr), 32'(cur.addr));
               chk("mon_raddr", 32'(apb_read_paddr),  32'(cur.addr));
               chk("mon_wdata", 32'(apb_write_data),  32'(cur.wdata));
            end
            hi_run = 0;
         end
         if (transfer) hi_run++;
         if (!transfer && prev_tr) begin
            chk("mon_xfer_len", 32'(hi_run), 32'(XFER));
            in_gap = 1'b1;
            if (!cur.rw) chk_rsp = 1'b1;
            lo_run = 0;
         end
         if (!transfer) lo_run++;
         chk("mon_fifo_count", 32'(fifo_count), 32'(occ));
         chk("mon_cmd_ready",  32'(cmd_ready),  32'(occ < DEPTH));
         chk("mon_busy",       32'(busy),       32'(occ != 0 || transfer || in_gap));
         prev_tr = transfer;
         if (cmd_valid && cmd_ready) begin
            pend   = 1'b1;
            pend_c = '{cmd_rw, cmd_addr, cmd_wdata, 8'h00};
         end
      end
   end

   bit rnd_rdy = 1'b0;

   task automatic cyc();
      @(posedge PCLK);
      #1;
   endtask

   task automatic push_cmd(input logic rw, input logic [7:0] a, input logic [7:0] d,
                           output int waited);
      bit acc;
      acc = 1'b0; waited = 0;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
      while (!acc && waited < 200) begin
         acc = cmd_ready;
         if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
         cyc();
         waited++;
      end
      cmd_valid = 1'b0;
      chk_t("push_accepted", acc);
   endtask

   task automatic wait_lvl(input logic v, output int n);
      n = 0;
      while (transfer !== v && n < 100) begin
         cyc();
         n++;
      end
      chk("wait_transfer_level", 32'(transfer), 32'(v));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 500) begin
         cyc();
         n++;
      end
      chk("wait_idle_busy", 32'(busy), 32'd0);
   endtask

   int w, a, b, hi;

   initial begin
      for (int i = 0; i < 256; i++) begin
         slave_mem[i] = 8'(i) ^ 8'h5A;
         model_mem[i] = 8'(i) ^ 8'h5A;
      end
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      cyc(); cyc();
      chk("rst_cmd_ready",  32'(cmd_ready),       32'd1);
      chk("rst_fifo_count", 32'(fifo_count),      32'd0);
      chk("rst_rsp_valid",  32'(rsp_valid),       32'd0);
      chk("rst_rsp_rdata",  32'(rsp_rdata),       32'd0);
      chk("rst_rsp_addr",   32'(rsp_addr),        32'd0);
      chk("rst_transfer",   32'(transfer),        32'd0);
      chk("rst_read_write", 32'(READ_WRITE),      32'd0);
      chk("rst_waddr",      32'(apb_write_paddr), 32'd0);
      chk("rst_wdata",      32'(apb_write_data),  32'd0);
      chk("rst_raddr",      32'(apb_read_paddr),  32'd0);
      chk("rst_busy",       32'(busy),            32'd0);
      @(negedge PCLK);
      PRESET = 1'b0;
      cyc();
      mon_en = 1'b1;

      // Single write: transfer rises on the edge after the push edge, held 2 cycles.
      push_cmd(1'b1, 8'h12, 8'hA5, w);
      chk("t1_not_yet",   32'(transfer),        32'd0);
      chk("t1_count",     32'(fifo_count),      32'd1);
      cyc();
      chk("t1_rise",      32'(transfer),        32'd1);
      chk("t1_rw",        32'(READ_WRITE),      32'd1);
      chk("t1_waddr",     32'(apb_write_paddr), 32'h12);
      chk("t1_wdata",     32'(apb_write_data),  32'hA5);
      cyc();
      chk("t1_hold",      32'(transfer),        32'd1);
      cyc();
      chk("t1_drop",      32'(transfer),        32'd0);
      chk("t1_gap_busy",  32'(busy),            32'd1);
      cyc();
      chk("t1_idle_busy", 32'(busy),            32'd0);
      chk("t1_no_rsp",    32'(rsp_valid),       32'd0);

      // Write then read of the same address.
      rsp_ready = 1'b1;
      push_cmd(1'b1, 8'h07, 8'h3C, w);
      push_cmd(1'b0, 8'h07, 8'($urandom), w);
      chk("t2_write_up", 32'(transfer), 32'd1);
      wait_lvl(1'b0, a);
      wait_lvl(1'b1, b);
      chk("t2_read_offset", 32'(a + b), 32'd4);
      chk("t2_read_rw",     32'(READ_WRITE),     32'd0);
      chk("t2_read_addr",   32'(apb_read_paddr), 32'h07);
      wait_lvl(1'b0, a);
      cyc();
      chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t2_rsp_rdata", 32'(rsp_rdata), 32'h3C);
      chk("t2_rsp_addr",  32'(rsp_addr),  32'h07);
      cyc();
      chk("t2_rsp_pulse", 32'(rsp_valid), 32'd0);

      // Fill the FIFO while the FSM is busy with a leading write.
      push_cmd(1'b1, 8'h3F, 8'($urandom), w);
      for (int k = 0; k < 4; k++) push_cmd(1'b1, 8'(8'h40 + k), 8'($urandom), w);
      chk("t3_full_count", 32'(fifo_count), 32'd4);
      chk("t3_full_ready", 32'(cmd_ready),  32'd0);
      push_cmd(1'b1, 8'h44, 8'($urandom), w);
      chk("t3_fifth_wait",  32'(w),          32'd2);
      chk("t3_after_count", 32'(fifo_count), 32'd4);
      wait_idle();

      // Two reads with the host not consuming responses.
      rsp_ready = 1'b0;
      push_cmd(1'b0, 8'h01, 8'($urandom), w);
      push_cmd(1'b0, 8'h02, 8'($urandom), w);
      wait_lvl(1'b0, a);
      cyc();
      chk("t4_rsp1_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rsp1_addr",  32'(rsp_addr),  32'h01);
      chk("t4_rsp1_rdata", 32'(rsp_rdata), 32'(8'h01 ^ 8'h5A));
      hi = 0;
      repeat (6) begin
         cyc();
         if (transfer) hi++;
      end
      chk("t4_stall_xfer",  32'(hi),         32'd0);
      chk("t4_stall_count", 32'(fifo_count), 32'd1);
      chk("t4_held_addr",   32'(rsp_addr),   32'h01);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      chk("t4_issue2",      32'(transfer),       32'd1);
      chk("t4_issue2_addr", 32'(apb_read_paddr), 32'h02);
      chk("t4_cleared",     32'(rsp_valid),      32'd0);
      wait_lvl(1'b0, a);
      cyc();
      chk("t4_rsp2_valid", 32'(rsp_valid), 32'd1);
      chk("t4_rsp2_addr",  32'(rsp_addr),  32'h02);
      chk("t4_rsp2_rdata", 32'(rsp_rdata), 32'(8'h02 ^ 8'h5A));

      // Head-of-line: a read at the head blocks the write behind it.
      push_cmd(1'b0, 8'h03, 8'($urandom), w);
      push_cmd(1'b1, 8'h04, 8'h99, w);
      hi = 0;
      repeat (6) begin
         cyc();
         if (transfer) hi++;
      end
      chk("t5_stall_xfer",  32'(hi),         32'd0);
      chk("t5_stall_count", 32'(fifo_count), 32'd2);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      chk("t5_read_first", 32'(READ_WRITE),     32'd0);
      chk("t5_read_addr",  32'(apb_read_paddr), 32'h03);
      wait_lvl(1'b0, a);
      wait_lvl(1'b1, b);
      chk("t5_write_rw",    32'(READ_WRITE),      32'd1);
      chk("t5_write_addr",  32'(apb_write_paddr), 32'h04);
      chk("t5_write_data",  32'(apb_write_data),  32'h99);
      chk("t5_rsp_pending", 32'(rsp_valid),       32'd1);
      chk("t5_rsp_addr",    32'(rsp_addr),        32'h03);
      wait_lvl(1'b0, a);
      cyc();

      // Reset in the middle of an ISSUE cycle with a response pending and FIFO occupied.
      push_cmd(1'b1, 8'hF1, 8'h11, w);
      push_cmd(1'b1, 8'hF2, 8'h22, w);
      push_cmd(1'b1, 8'hF3, 8'h33, w);
      chk("t6_pre_xfer",  32'(transfer),   32'd1);
      chk("t6_pre_count", 32'(fifo_count), 32'd2);
      chk("t6_pre_rsp",   32'(rsp_valid),  32'd1);
      mon_en = 1'b0;
      #2;
      PRESET = 1'b1;
      #1;
      chk("t6_rst_xfer",  32'(transfer),   32'd0);
      chk("t6_rst_count", 32'(fifo_count), 32'd0);
      chk("t6_rst_rsp",   32'(rsp_valid),  32'd0);
      chk("t6_rst_addr",  32'(rsp_addr),   32'd0);
      chk("t6_rst_ready", 32'(cmd_ready),  32'd1);
      chk("t6_rst_busy",  32'(busy),       32'd0);
      cyc();
      PRESET = 1'b0;
      cyc();
      mon_en = 1'b1;
      push_cmd(1'b1, 8'h20, 8'h77, w);
      cyc();
      chk("t6_post_xfer",  32'(transfer),        32'd1);
      chk("t6_post_addr",  32'(apb_write_paddr), 32'h20);
      chk("t6_post_wdata", 32'(apb_write_data),  32'h77);
      wait_idle();

      // Random commands over a small address window with a randomly stalling host.
      rnd_rdy = 1'b1;
      for (int n = 0; n < 40; n++) begin
         push_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), w);
         repeat ($urandom_range(0, 3)) begin
            rsp_ready = 1'($urandom_range(0, 1));
            cyc();
         end
      end
      rnd_rdy   = 1'b0;
      rsp_ready = 1'b1;
      wait_idle();
      repeat (3) cyc();
      chk("rand_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
